fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Decoupled instruction-fetch stage for the five-stage pipelined core. Replaces the free-running pc_counter + imemory pairing of the single-cycle datapath.
- Owns the fetch PC and issues sequential requests to the instruction memory, which may have multi-cycle latency.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents them to decode over a valid/ready handshake.
- On a taken branch/jump redirect from execute: flushes buffered and in-flight fetches, then restarts at the target.

Parameters:
- XLEN, 32: data/address width.
- DEPTH, 4: queue entries, and also the maximum outstanding imem requests (power of 2, ≥2).
- RESET_PC, 32'h0100_0000: fetch PC after reset.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- imem_req  out  1  request strobe; one request per cycle when high.
- imem_addr  out  XLEN  word address of request (bits [1:0] always 0).
- imem_rvalid  in  1  response valid; responses return in request order.
- imem_rdata  in  32  instruction word for the oldest outstanding request.
- out_valid  out  1  queue head valid.
- out_inst  out  32  head instruction.
- out_pc  out  XLEN  head PC.
- out_ready  in  1  decode accepts head this cycle.
- redir_valid  in  1  redirect (taken branch/jump) this cycle.
- redir_pc  in  XLEN  redirect target; bits [1:0] ignored, forced to 0.

Behaviour:
- Reset (async, immediate):
  - fetch_pc = resp_pc = RESET_PC.
  - count = outstanding = drop_cnt = 0.
  - out_valid = 0, imem_req = 0, out_inst = 0, out_pc = 0.
  - Reset asserted mid-operation discards everything, including in-flight requests; imem_rvalid while outstanding == 0 and drop_cnt == 0 is ignored.
- Issue (combinational):
  - imem_req = !reset && !redir_valid && (count + outstanding < DEPTH).
  - imem_addr = fetch_pc.
  - On an issue edge: fetch_pc += 4 (wraps modulo 2^XLEN), outstanding += 1.
- Response:
  - On imem_rvalid, outstanding -= 1.
  - If drop_cnt > 0: drop_cnt -= 1 and the word is discarded.
  - Otherwise push {imem_rdata, resp_pc} and resp_pc += 4.
  - Credit rule guarantees a push never hits a full queue.
- Output:
  - out_valid = (count != 0); head fields driven from a registered FIFO read.
  - Pop when out_valid && out_ready.
  - No bypass: a word returned on cycle N is visible at out_valid on cycle N+1 at the earliest.
  - out_inst/out_pc hold stable while out_valid && !out_ready.
  - Push and pop in the same cycle: count unchanged; empty queue with push+ready → no pop that cycle.
- Redirect (redir_valid high at an edge):
  - fetch_pc = resp_pc = {redir_pc[XLEN-1:2], 2'b00}; count = 0 (queue flushed); no request is issued that cycle.
  - drop_cnt = outstanding − (imem_rvalid ? 1 : 0) + (imem_rvalid && drop_cnt == 0 ? 0 : 0): i.e. every request still in flight after this edge is dropped. A response arriving on the redirect edge itself is also discarded.
  - A pop requested on the redirect edge is ignored (the head is already flushed); out_valid = 0 the next cycle.
  - Back-to-back redirects: the latest wins; drop_cnt is recomputed each time.
  - First post-redirect request is issued the cycle after redirect if credit allows.
- Counters: count, outstanding and drop_cnt are clog2(DEPTH+1) bits wide. Invariant: count + outstanding ≤ DEPTH. drop_cnt ≤ outstanding.
- Full: count == DEPTH → imem_req = 0 until a pop.
- Empty: out_valid = 0, out_inst/out_pc hold their last values.

Test Plan:
- Reset release, imem latency 1, out_ready = 1 → imem_addr 0x01000000, 0x01000004, …; first out_valid two cycles after first req, with out_pc = 0x01000000; thereafter one instruction per cycle, PCs +4.
- out_ready = 0 for 10 cycles, latency 1, DEPTH = 4 → exactly 4 requests issued, count = 4, imem_req low; raising ready drains 0x01000000..0x0100000C in order.
- Latency 3, redirect to 0x01000103 while 3 requests are in flight → next request at 0x01000100; the 3 stale responses are dropped; first out_pc = 0x01000100.
- Redirect on the same edge as an imem_rvalid and an out_ready pop → response discarded, no pop, out_valid = 0 next cycle, drop_cnt = outstanding − 1.
- Redirect to 0xFFFFFFFC (XLEN = 32) → addresses 0xFFFFFFFC then 0x00000000 (wrap).
- Async reset pulsed mid-burst with 2 outstanding; late imem_rvalid pulses arrive after release → ignored; fetch restarts at 0x01000000 with out_valid = 0 until the new response.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch queue bus bundle: instruction-memory request/response, decode-side
// valid/ready output and the execute-stage redirect.
interface fetch_queue_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            out_valid;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;
    logic            out_ready;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;

    // Fetch stage side
    modport master (
        output imem_req, imem_addr, out_valid, out_inst, out_pc,
        input  imem_rvalid, imem_rdata, out_ready, redir_valid, redir_pc
    );

    // Environment side (imem, decode, execute)
    modport slave (
        input  imem_req, imem_addr, out_valid, out_inst, out_pc,
        output imem_rvalid, imem_rdata, out_ready, redir_valid, redir_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: owns the fetch PC, issues sequential imem
// requests under a credit limit, buffers returned words with their PCs and
// flushes buffered plus in-flight work on a redirect.
module fetch_queue #(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(32'h0100_0000)
) (
    input  logic          clock,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = CW + 1;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head, head_next;
    logic [PW-1:0]   wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [XLEN-1:0] fetch_pc, resp_pc, fetch_pc_next, resp_pc_next, redir_base;
    logic [CW-1:0]   count, outstanding, drop_cnt;
    logic [CW-1:0]   count_next, outstanding_next, drop_cnt_next, remain;
    logic            valid, valid_next;
    logic            issue, resp, push, pop, flush;

    // Credit check: buffered plus in-flight words never exceed the queue size
    always_comb begin
        issue = !reset && !bus.redir_valid &&
                ((SW'(count) + SW'(outstanding)) < SW'(DEPTH));
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = valid;
    assign bus.out_inst  = head.inst;
    assign bus.out_pc    = head.pc;

    // Next-state for PCs, counters, pointers and the registered head
    always_comb begin
        flush            = bus.redir_valid;
        resp             = bus.imem_rvalid && (outstanding != '0);
        pop              = (count != '0) && bus.out_ready && !flush;
        push             = resp && (drop_cnt == '0) && !flush;
        redir_base       = bus.redir_pc & ~XLEN'(3);
        fetch_pc_next    = fetch_pc;
        resp_pc_next     = resp_pc;
        count_next       = count;
        drop_cnt_next    = drop_cnt;
        wr_ptr_next      = wr_ptr;
        rd_ptr_next      = rd_ptr;
        outstanding_next = outstanding + CW'(issue) - CW'(resp);
        remain           = count - CW'(pop);
        head_next        = head;

        if (flush) begin
            // Every request still in flight after this edge becomes stale
            fetch_pc_next = redir_base;
            resp_pc_next  = redir_base;
            count_next    = '0;
            drop_cnt_next = outstanding - CW'(resp);
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
        end else begin
            if (issue) begin
                fetch_pc_next = fetch_pc + XLEN'(4);
            end
            if (resp && (drop_cnt != '0)) begin
                drop_cnt_next = drop_cnt - CW'(1);
            end
            if (push) begin
                resp_pc_next = resp_pc + XLEN'(4);
                wr_ptr_next  = wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr + PW'(1);
            end
            count_next = count + CW'(push) - CW'(pop);
        end

        // Head shows the incoming word when it lands in an otherwise empty queue
        if (count_next != '0) begin
            if (push && (remain == '0)) begin
                head_next = '{inst: bus.imem_rdata, pc: resp_pc};
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
        valid_next = (count_next != '0);
    end

    // State registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC & ~XLEN'(3);
            resp_pc     <= RESET_PC & ~XLEN'(3);
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            valid       <= 1'b0;
            head        <= '0;
        end else begin
            fetch_pc    <= fetch_pc_next;
            resp_pc     <= resp_pc_next;
            count       <= count_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_cnt_next;
            wr_ptr      <= wr_ptr_next;
            rd_ptr      <= rd_ptr_next;
            valid       <= valid_next;
            head        <= head_next;
        end
    end

    // Queue storage; contents only become visible through the head register
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= '{inst: bus.imem_rdata, pc: resp_pc};
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: an in-order imem model with random
// latency and a queue-based reference of the delivered instruction stream.
module tb_fetch_queue;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0100_0000;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(XLEN)) bus();

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          last_due = 0;
    logic        junk = 1'b0;
    logic        last_resp;
    logic [31:0] mpc;
    logic [97:0] obs_vec, exp_vec;
    req_t        pend[$];
    ent_t        expq[$];
    logic [31:0] popped[$];
    logic [31:0] addrs[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic clear_model();
        pend.delete();
        expq.delete();
        popped.delete();
        addrs.delete();
        mpc      = RESET_PC;
        epoch    = epoch + 1;
        last_due = cyc;
    endtask

    // One clock cycle: drive inputs, capture observed vs expected, advance model
    task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt);
        logic  resp;
        logic  exp_req;
        req_t  r;
        ent_t  e;
        int    lat;
        bus.out_ready   = rdy;
        bus.redir_valid = redir;
        bus.redir_pc    = tgt;
        resp = 1'b0;
        r    = '{addr: 32'h0, epoch: -1, due: 0};
        if (junk) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hBAD0_0BAD;
            junk = 1'b0;
        end else if (pend.size() != 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            resp = 1'b1;
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(r.addr);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end
        last_resp = resp;
        #1;
        exp_req = !redir && ((expq.size() + pend.size() + int'(resp)) < int'(DEPTH));
        exp_vec = '0;
        if (expq.size() != 0) exp_vec[97:33] = {1'b1, expq[0].pc, expq[0].inst};
        if (exp_req) exp_vec[32:0] = {1'b1, mpc};
        obs_vec = '0;
        if (bus.out_valid) obs_vec[97:33] = {1'b1, bus.out_pc, bus.out_inst};
        if (bus.imem_req) obs_vec[32:0] = {1'b1, bus.imem_addr};
        if (bus.out_valid && rdy && !redir) popped.push_back(bus.out_pc);
        if (bus.imem_req) addrs.push_back(bus.imem_addr);

        if (redir) begin
            expq.delete();
            epoch = epoch + 1;
            mpc   = {tgt[31:2], 2'b00};
        end else begin
            if (expq.size() != 0 && rdy) void'(expq.pop_front());
            if (resp && r.epoch == epoch) begin
                e.pc   = r.addr;
                e.inst = mem_word(r.addr);
                expq.push_back(e);
            end
            if (exp_req) begin
                lat = int'($urandom_range(lat_max, lat_min));
                r.addr  = mpc;
                r.epoch = epoch;
                r.due   = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                last_due = r.due;
                pend.push_back(r);
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
        cyc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.out_ready   = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic test_reset();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.out_ready   = 1'b1;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = '0;
        #1 rst = 1'b1;
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
        tests++; if (bus.out_pc !== 32'h0) begin fails++; $display("FAIL reset_pc got=%h exp=0", bus.out_pc); end
        tests++; if (bus.out_inst !== 32'h0) begin fails++; $display("FAIL reset_inst got=%h exp=0", bus.out_inst); end
        reset_dut();
    endtask

    task automatic test_stream();
        int first_v = -1;
        reset_dut();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (first_v < 0 && obs_vec[97]) first_v = i;
            tests++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        tests++; if (first_v != 2) begin fails++; $display("FAIL stream_first_valid got=%0d exp=2", first_v); end
        tests++; if (addrs.size() < 2 || addrs[0] !== RESET_PC || addrs[1] !== RESET_PC + 32'd4) begin
            fails++; $display("FAIL stream_addrs got_n=%0d exp first=%h", addrs.size(), RESET_PC);
        end
        tests++; if (popped.size() < 10 || popped[0] !== RESET_PC || popped[9] !== RESET_PC + 32'd36) begin
            fails++; $display("FAIL stream_pcs got_n=%0d exp>=10 from %h", popped.size(), RESET_PC);
        end
    endtask

    task automatic test_stall();
        reset_dut();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'h0);
            tests++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL stall cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        #1;
        tests++; if (addrs.size() != int'(DEPTH)) begin fails++; $display("FAIL stall_issued got=%0d exp=%0d", addrs.size(), DEPTH); end
        tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL stall_req got=%b exp=0", bus.imem_req); end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'h0);
            tests++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL drain cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (popped.size() <= i || popped[i] !== RESET_PC + 32'(4 * i)) begin
                fails++; $display("FAIL drain_order idx=%0d got_n=%0d exp=%h", i, popped.size(), RESET_PC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_inflight();
        int n = 0;
        reset_dut();
        lat_min = 3; lat_max = 3;
        while (pend.size() < 3 && n < 10) begin
            step(1'b1, 1'b0, 32'h0);
            n++;
            tests++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL inflight_pre cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        tests++; if (pend.size() != 3) begin fails++; $display("FAIL inflight_setup got=%0d exp=3", pend.size()); end
        step(1'b1, 1'b1, 32'h0100_0103);
        popped.delete();
        addrs.delete();
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b0, 32'h0);
            tests++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL inflight cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        tests++; if (addrs.size() == 0 || addrs[0] !== 32'h0100_0100) begin fails++; $display("FAIL inflight_addr got_n=%0d exp=01000100", addrs.size()); end
        tests++; if (popped.size() == 0 || popped[0] !== 32'h0100_0100) begin fails++; $display("FAIL inflight_pc got_n=%0d exp=01000100", popped.size()); end
    endtask

    task automatic test_redirect_same_edge();
        reset_dut();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 32'h0);
            tests++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL same_pre cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        step(1'b1, 1'b1, 32'h0100_0040);
        tests++; if (obs_vec !== exp_vec) begin fails++; $display("FAIL same_edge cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        tests++; if (!(last_resp && obs_vec[97])) begin fails++; $display("FAIL same_setup got resp=%b valid=%b exp 1 1", last_resp, obs_vec[97]); end
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL same_flush got=%b exp=0", bus.out_valid); end
        popped.delete();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 32'h0);
            tests++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL same_post cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        tests++; if (popped.size() == 0 || popped[0] !== 32'h0100_0040) begin fails++; $display("FAIL same_pc got_n=%0d exp=01000040", popped.size()); end
    endtask

    task automatic test_wrap();
        reset_dut();
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0);
            tests++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL wrap_pre cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        step(1'b1, 1'b1, 32'hFFFF_FFFE);
        addrs.delete();
        popped.delete();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'h0);
            tests++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        tests++; if (addrs.size() < 2 || addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0) begin fails++; $display("FAIL wrap_addr got_n=%0d exp fffffffc,0", addrs.size()); end
        tests++; if (popped.size() < 2 || popped[0] !== 32'hFFFF_FFFC || popped[1] !== 32'h0) begin fails++; $display("FAIL wrap_pc got_n=%0d exp fffffffc,0", popped.size()); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0);
            tests++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL rmid_pre cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        tests++; if (pend.size() != 2 || bus.out_valid !== 1'b1) begin fails++; $display("FAIL rmid_setup got pend=%0d valid=%b exp 2 1", pend.size(), bus.out_valid); end
        #2 rst = 1'b1;
        #1;
        tests++; if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0) begin fails++; $display("FAIL rmid_ctrl got valid=%b req=%b exp 0 0", bus.out_valid, bus.imem_req); end
        tests++; if (bus.out_pc !== 32'h0 || bus.out_inst !== 32'h0) begin fails++; $display("FAIL rmid_head got pc=%h inst=%h exp 0 0", bus.out_pc, bus.out_inst); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        junk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'h0);
            tests++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL rmid cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        tests++; if (popped.size() == 0 || popped[0] !== RESET_PC) begin fails++; $display("FAIL rmid_pc got_n=%0d exp=%h", popped.size(), RESET_PC); end
    endtask

    task automatic test_random();
        logic rdy, redir;
        reset_dut();
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            rdy   = ($urandom % 10) < 7;
            redir = ($urandom % 25) == 0;
            step(rdy, redir, $urandom);
            tests++;
            if (obs_vec !== exp_vec) begin fails++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_same_edge();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
